alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
No parameters; all datapaths fixed at 32 bits, ALU control fixed at 3 bits.
REQ-001 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low; SHALL be the only reset.
REQ-003 reqN_valid  input  1  (N = 0,1) requester N presents an operation.
REQ-004 reqN_ready  output  1  operation of requester N is accepted this cycle.
REQ-005 reqN_src_1  input  32  first operand of requester N.
REQ-006 reqN_src_2  input  32  second operand of requester N.
REQ-007 reqN_control  input  3  ALU control code of requester N.
REQ-008 rspN_valid  output  1  response slot N holds a result.
REQ-009 rspN_ready  input  1  requester N consumes its response.
REQ-010 rspN_result  output  32  registered ALU result for requester N.
REQ-011 rspN_zero  output  1  registered ALU zero flag for requester N.
REQ-012 alu_src_1  output  32  operand 1 driven to the shared ALU.
REQ-013 alu_src_2  output  32  operand 2 driven to the shared ALU.
REQ-014 alu_control  output  3  control driven to the shared ALU.
REQ-015 alu_result  input  32  combinational result returned by the shared ALU.
REQ-016 alu_zero  input  1  combinational zero flag returned by the shared ALU.

Function
REQ-017 Each response slot N SHALL be a two-state machine: EMPTY (rspN_valid=0), FULL (rspN_valid=1).
REQ-018 Requester N SHALL be eligible when reqN_valid=1 and slot N is EMPTY, or slot N is FULL with rspN_ready=1 in the same cycle.
REQ-019 At most one requester SHALL be granted per cycle; reqN_ready=1 only for the granted requester.
REQ-020 If exactly one requester is eligible, it SHALL be granted regardless of round-robin priority.
REQ-021 If both are eligible, the requester not granted most recently SHALL be granted (register last_grant).
REQ-022 last_grant SHALL update only in cycles where a grant occurs.
REQ-023 While granted, alu_src_1/alu_src_2/alu_control SHALL combinationally equal the granted requester's operands; with no grant they SHALL be 0/0/3'b000.
REQ-024 On the clock edge of a grant, alu_result and alu_zero SHALL be captured into rspN_result/rspN_zero and slot N SHALL become FULL; latency accept-to-rspN_valid = 1 cycle.
REQ-025 A FULL slot SHALL go EMPTY on rspN_valid=1 and rspN_ready=1 unless refilled by a grant in the same cycle, in which case it SHALL stay FULL with the new result.
REQ-026 rspN_result/rspN_zero SHALL hold their value while slot N is FULL and not drained.
REQ-027 reqN_ready SHALL NOT depend combinationally on reqN_ready of the other requester's response path beyond REQ-018; no combinational loop through rspN_ready to reqN_valid is permitted.
REQ-028 The block SHALL pass the ALU result unmodified; unsupported control codes yield whatever the ALU returns (currently 0, zero=1).

Reset
REQ-029 On rst_n=0, immediately: rspN_valid=0, rspN_result=0, rspN_zero=0, slots EMPTY, last_grant=1 (requester 0 wins first tie).
REQ-030 Reset asserted mid-operation SHALL discard any held response and any operation being accepted that cycle.
REQ-031 reqN_ready SHALL be 0 while rst_n=0.

Verification
REQ-032 Reset release, both reqN_valid=1 at first edge -> req0_ready=1, req1_ready=0; next cycle req1 granted.
REQ-033 Only req0: src_1=5, src_2=7, control=000 -> next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
REQ-034 Both requesters valid continuously, rspN_ready=1 -> grants alternate 0,1,0,1 for 8 cycles, each result delivered one cycle after its grant.
REQ-035 rsp0 FULL with rsp0_ready=0, both valid -> req1 granted every cycle, req0_ready=0; raising rsp0_ready -> req0 granted that cycle, rsp0 stays valid with new result.
REQ-036 req1: src_1=0, src_2=0, control=000 -> rsp1_result=0, rsp1_zero=1; control=001 with 3,4 -> rsp1_result=0, rsp1_zero=1.
REQ-037 rsp1_valid=1 held, rst_n driven low between clock edges -> rsp1_valid=0 before the next edge; after release first tie goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between
// two requesters and holds each requester's result in its own response slot.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready            operation handshake for requester N (N = 0,1)
//   reqN_src_1/src_2/control    operands and ALU control code of requester N
//   rspN_valid/ready            response handshake for requester N
//   rspN_result/zero            registered ALU result/zero flag for requester N
//   alu_src_1/src_2/control     operands presented to the shared ALU
//   alu_result/zero             combinational return from the shared ALU

// Per-requester response slot: EMPTY/FULL state plus the captured result.
module alu_arbiter_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        rsp_ready,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_zero
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

  slot_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A grant always wins over a drain: the slot refills in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (gnt) state_d = FULL;
      FULL: begin
        if (gnt)            state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (gnt) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end
  end

  assign rsp_valid = (state_q == FULL);
endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src_1,
  input  logic [31:0] req0_src_2,
  input  logic [2:0]  req0_control,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src_1,
  input  logic [31:0] req1_src_2,
  input  logic [2:0]  req1_control,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] alu_src_1,
  output logic [31:0] alu_src_2,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]       req_valid, rsp_ready, rsp_valid, rsp_zero;
  logic [NUM_REQ-1:0]       elig, gnt;
  logic [NUM_REQ-1:0][31:0] src_1, src_2, rsp_result;
  logic [NUM_REQ-1:0][2:0]  ctrl;
  logic                     last_grant;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign src_1     = {req1_src_1, req0_src_1};
  assign src_2     = {req1_src_2, req0_src_2};
  assign ctrl      = {req1_control, req0_control};

  // Eligible if the slot can take a result this edge. rsp_ready is the only
  // response-side input used, so there is no path back to reqN_valid.
  // Gating with rst_n keeps both readies low while reset is held.
  assign elig = req_valid & (~rsp_valid | rsp_ready) & {NUM_REQ{rst_n}};

  // Tie goes to whoever was not granted last; a lone eligible requester wins.
  always_comb begin
    gnt = elig;
    if (&elig) gnt = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
  end

  // gnt is one-hot or zero, so at most one term applies.
  always_comb begin
    alu_src_1   = '0;
    alu_src_2   = '0;
    alu_control = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (gnt[n]) begin
        alu_src_1   = src_1[n];
        alu_src_2   = src_2[n];
        alu_control = ctrl[n];
      end
    end
  end

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_slot
    alu_arbiter_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .gnt        (gnt[n]),
      .rsp_ready  (rsp_ready[n]),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid[n]),
      .rsp_result (rsp_result[n]),
      .rsp_zero   (rsp_zero[n])
    );
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_zero   = rsp_zero[0];
  assign rsp1_zero   = rsp_zero[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a table of per-cycle stimulus with expected grants,
// a small ALU in the bench, and a scoreboard that queues the expected result
// at each grant and checks it when the response slot loads.
module tb_alu_arbiter;
  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src_1, req0_src_2, req1_src_1, req1_src_2;
  logic [2:0]  req0_control, req1_control;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_src_1, alu_src_2, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;

  int n_chk = 0;
  int n_fail = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src_1(req0_src_1),
    .req0_src_2(req0_src_2), .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src_1(req1_src_1),
    .req1_src_2(req1_src_2), .req1_control(req1_control),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero),
    .alu_src_1(alu_src_1), .alu_src_2(alu_src_2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 000 add, 010 sub, 011 and, 100 or, 101 xor, else 0.
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    logic [31:0] r;
    case (c)
      3'b000:  r = a + b;
      3'b010:  r = a - b;
      3'b011:  r = a & b;
      3'b100:  r = a | b;
      3'b101:  r = a ^ b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_ref(alu_src_1, alu_src_2, alu_control);

  typedef struct {
    logic v0, v1, rr0, rr1;
    logic [31:0] a0, b0;
    logic [2:0]  c0;
    logic [31:0] a1, b1;
    logic [2:0]  c1;
    logic e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic v1, input logic rr0, input logic rr1,
                              input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                              input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                              input logic e0, input logic e1);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.rr0 = rr0; t.rr1 = rr1;
    t.a0 = a0; t.b0 = b0; t.c0 = c0; t.a1 = a1; t.b1 = b1; t.c1 = c1;
    t.e0 = e0; t.e1 = e1;
    return t;
  endfunction

  // Scoreboard state: expected {zero,result} per slot, load-pending flag,
  // expected rspN_valid, and the value a full slot must keep holding.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [1:0]  pend, mv;
  logic [32:0] held [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_clear();
    q0.delete(); q1.delete();
    pend = 2'b00; mv = 2'b00;
  endtask

  // Called on the falling edge, before the rising edge that acts on inputs.
  task automatic sample();
    logic        vld, zr, rdy, rr;
    logic [31:0] res;
    logic [32:0] e;
    for (int n = 0; n < 2; n++) begin
      vld = n ? rsp1_valid  : rsp0_valid;
      res = n ? rsp1_result : rsp0_result;
      zr  = n ? rsp1_zero   : rsp0_zero;
      rdy = n ? req1_ready  : req0_ready;
      rr  = n ? rsp1_ready  : rsp0_ready;
      chk($sformatf("rsp%0d_valid", n), {31'd0, vld}, {31'd0, mv[n]});
      if (pend[n]) begin
        if ((n ? q1.size() : q0.size()) == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty%0d: got no entry expected one", n);
          e = '0;
        end else e = n ? q1.pop_front() : q0.pop_front();
        chk($sformatf("rsp%0d_result", n), res, e[31:0]);
        chk($sformatf("rsp%0d_zero", n), {31'd0, zr}, {31'd0, e[32]});
        held[n] = e;
        pend[n] = 1'b0;
      end else if (mv[n]) begin
        chk($sformatf("rsp%0d_hold", n), res, held[n][31:0]);
      end
      if (rdy) begin
        e = n ? alu_ref(req1_src_1, req1_src_2, req1_control)
              : alu_ref(req0_src_1, req0_src_2, req0_control);
        if (n == 0) q0.push_back(e); else q1.push_back(e);
        pend[n] = 1'b1;
        mv[n]   = 1'b1;
      end else if (mv[n] && rr) begin
        mv[n] = 1'b0;
      end
    end
  endtask

  task automatic drive(input vec_t t);
    req0_valid = t.v0; req1_valid = t.v1; rsp0_ready = t.rr0; rsp1_ready = t.rr1;
    req0_src_1 = t.a0; req0_src_2 = t.b0; req0_control = t.c0;
    req1_src_1 = t.a1; req1_src_2 = t.b1; req1_control = t.c1;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_vec(input vec_t t, input int idx);
    logic [31:0] ea, eb;
    logic [2:0]  ec;
    drive(t);
    @(negedge clk);
    chk($sformatf("req0_ready[%0d]", idx), {31'd0, req0_ready}, {31'd0, t.e0});
    chk($sformatf("req1_ready[%0d]", idx), {31'd0, req1_ready}, {31'd0, t.e1});
    ea = t.e0 ? t.a0 : (t.e1 ? t.a1 : 32'd0);
    eb = t.e0 ? t.b0 : (t.e1 ? t.b1 : 32'd0);
    ec = t.e0 ? t.c0 : (t.e1 ? t.c1 : 3'd0);
    chk($sformatf("alu_src_1[%0d]", idx), alu_src_1, ea);
    chk($sformatf("alu_src_2[%0d]", idx), alu_src_2, eb);
    chk($sformatf("alu_control[%0d]", idx), {29'd0, alu_control}, {29'd0, ec});
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
    chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
    chk({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    chk({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    chk({tag, "_rsp0_result"}, rsp0_result, 32'd0);
    chk({tag, "_rsp1_result"}, rsp1_result, 32'd0);
    chk({tag, "_rsp0_zero"}, {31'd0, rsp0_zero}, 32'd0);
    chk({tag, "_rsp1_zero"}, {31'd0, rsp1_zero}, 32'd0);
    chk({tag, "_alu_src_1"}, alu_src_1, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

  vec_t tbl [19];

  initial begin
    tbl[0]  = mk(1,1,1,1, 5,7,3'd0,             1,2,3'd0,             1,0);
    tbl[1]  = mk(1,1,1,1, 5,7,3'd0,             1,2,3'd0,             0,1);
    tbl[2]  = mk(1,0,1,1, 32'hFFFFFFFF,1,3'd0,  0,0,3'd0,             1,0);
    tbl[3]  = mk(1,1,1,1, 100,1,3'd2,           20,22,3'd3,           0,1);
    tbl[4]  = mk(1,1,1,1, 100,1,3'd2,           20,22,3'd3,           1,0);
    tbl[5]  = mk(1,1,1,1, 7,7,3'd2,             8,1,3'd4,             0,1);
    tbl[6]  = mk(1,1,1,1, 7,7,3'd2,             8,1,3'd4,             1,0);
    tbl[7]  = mk(1,1,1,1, 32'hA5A5A5A5,32'h0F0F0F0F,3'd5, 32'h80000000,32'h80000000,3'd0, 0,1);
    tbl[8]  = mk(1,1,1,1, 32'hA5A5A5A5,32'h0F0F0F0F,3'd5, 32'h80000000,32'h80000000,3'd0, 1,0);
    tbl[9]  = mk(1,1,1,1, 3,4,3'd0,             6,6,3'd2,             0,1);
    tbl[10] = mk(1,1,1,1, 3,4,3'd0,             6,6,3'd2,             1,0);
    tbl[11] = mk(1,1,0,1, 11,22,3'd0,           1,1,3'd0,             0,1);
    tbl[12] = mk(1,1,0,1, 11,22,3'd0,           1,1,3'd0,             0,1);
    tbl[13] = mk(1,1,0,1, 11,22,3'd0,           1,1,3'd0,             0,1);
    tbl[14] = mk(1,1,1,1, 11,22,3'd0,           1,1,3'd0,             1,0);
    tbl[15] = mk(0,1,1,1, 0,0,3'd0,             0,0,3'd0,             0,1);
    tbl[16] = mk(0,1,1,1, 0,0,3'd0,             3,4,3'd1,             0,1);
    tbl[17] = mk(0,0,1,1, 0,0,3'd0,             0,0,3'd0,             0,0);
    tbl[18] = mk(0,0,1,1, 0,0,3'd0,             0,0,3'd0,             0,0);

    // Reset held with both requesters asking: nothing may be accepted.
    rst_n = 1'b0;
    sb_clear();
    drive(mk(1,1,1,1, 5,7,3'd0, 1,2,3'd0, 0,0));
    repeat (2) @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(tbl[i], i);

    // Load slot 1 and leave it undrained, then reset between edges.
    run_vec(mk(0,1,1,0, 0,0,3'd0, 9,1,3'd0, 0,1), 100);
    run_vec(mk(0,0,1,0, 0,0,3'd0, 0,0,3'd0, 0,0), 101);
    drive(mk(1,1,1,1, 2,2,3'd0, 3,3,3'd0, 0,0));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    sb_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(mk(1,1,1,1, 2,2,3'd0, 3,3,3'd0, 1,0), 102);
    run_vec(mk(1,1,1,1, 2,2,3'd0, 3,3,3'd0, 0,1), 103);
    run_vec(mk(0,0,1,1, 0,0,3'd0, 0,0,3'd0, 0,0), 104);
    run_vec(mk(0,0,1,1, 0,0,3'd0, 0,0,3'd0, 0,0), 105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
